// File: rtl/ahbl_to_apb3_bridge.sv
// AHB-Lite slave to APB3 master bridge on a single clock domain.
// Each AHB NONSEQ/SEQ beat becomes one APB3 SETUP/ACCESS transaction. AHB wait
// states are inserted until PREADY. PSLVERR, or an optional ACCESS-phase
// timeout, is returned as a two-cycle AHB ERROR response.
// All outputs are registered. They are decoded from next_state, so each
// output changes on the same edge as the state that defines it.
module ahbl_to_apb3_bridge #(
  parameter int APB_AWIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADYIN,
  output logic                  HREADYOUT,
  output logic [31:0]           HRDATA,
  output logic                  HRESP,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [APB_AWIDTH-1:0] PADDR,
  output logic [31:0]           PWDATA,
  input  logic                  PREADY,
  input  logic [31:0]           PRDATA,
  input  logic                  PSLVERR
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Counter value seen in the last ACCESS cycle allowed before the abort.
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
  } state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] to_cnt;
  logic             addr_valid, accept, timeout_hit;
  logic             hreadyout_d, hresp_d, psel_d, penable_d;
  logic             unused_inputs;

  // A valid address phase is sampled only while HREADYOUT is high (IDLE/ERR2).
  assign addr_valid  = HSEL & HREADYIN & HTRANS[1];
  assign accept      = addr_valid & ((state == S_IDLE) | (state == S_ERR2));
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && !PREADY && (to_cnt == TO_LAST);

  // APB3 is word-only and each beat is independent, so size, burst and
  // SEQ-vs-NONSEQ carry no information for the bridge.
  assign unused_inputs = ^{HSIZE, HBURST, HTRANS[0], HADDR};

  // State register.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    // NOTE: flops use non-blocking assignments so every register sees the pre-edge values.
    if (!HRESETN) state <= S_IDLE;
    else          state <= next_state;
  end

  // Next-state logic. PREADY takes priority over the timeout.
  always_comb begin
    // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
    next_state = state;
    case (state)
      S_IDLE, S_ERR2: next_state = accept ? (HWRITE ? S_WDATA : S_SETUP) : S_IDLE;
      S_WDATA:        next_state = S_SETUP;
      S_SETUP:        next_state = S_ACCESS;
      S_ACCESS: begin
        if (PREADY)           next_state = PSLVERR ? S_ERR1 : S_IDLE;
        else if (timeout_hit) next_state = S_ERR1;
      end
      S_ERR1:         next_state = S_ERR2;
      default:        next_state = S_IDLE;
    endcase
  end

  // Output decode of the state being entered.
  always_comb begin
    hreadyout_d = (next_state == S_IDLE)  || (next_state == S_ERR2);
    hresp_d     = (next_state == S_ERR1)  || (next_state == S_ERR2);
    psel_d      = (next_state == S_SETUP) || (next_state == S_ACCESS);
    penable_d   = (next_state == S_ACCESS);
  end

  // Registered handshake and APB control outputs.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
    end else begin
      HREADYOUT <= hreadyout_d;
      HRESP     <= hresp_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
    end
  end

  // Address/data capture, read-data return and the ACCESS timeout counter.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
      HRDATA <= '0;
      to_cnt <= '0;
    end else begin
      if (accept) begin
        PADDR  <= HADDR[APB_AWIDTH-1:0];
        PWRITE <= HWRITE;
      end
      if (state == S_WDATA) PWDATA <= HWDATA;
      if ((state == S_ACCESS) && PREADY && !PSLVERR && !PWRITE) HRDATA <= PRDATA;
      if (state == S_SETUP)                  to_cnt <= '0;
      else if ((state == S_ACCESS) && !PREADY) to_cnt <= to_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ahbl_to_apb3_bridge.sv
// Testbench for ahbl_to_apb3_bridge (TIMEOUT_CYCLES = 4).
// An AHB driver issues back-to-back groups of transfers from a vector table
// and pushes each expectation to a scoreboard queue. A responder process
// plays the APB slave: it pops the matching entry at SETUP, checks the
// address and data, and answers after the configured number of PREADY-low
// cycles.
module tb_ahbl_to_apb3_bridge;

  localparam int TIMEOUT  = 4;
  localparam int STUCK    = 99;   // PREADY never rises
  localparam int MAX_WAIT = 50;

  typedef struct {
    logic        nonseq;      // 1 = NONSEQ, 0 = IDLE with HSEL high
    logic        write;
    logic [31:0] addr;
    logic [31:0] data;        // HWDATA for writes, PRDATA answer for reads
    int          waits;       // PREADY-low ACCESS cycles before PREADY
    logic        slverr;
    int          exp_ws;      // AHB cycles with HREADYOUT=0
    logic        exp_resp;    // HRESP at completion
    logic [31:0] exp_hrdata;  // HRDATA at completion
    int          exp_acc;     // APB ACCESS cycles
  } vec_t;

  logic        hclk, hresetn, hsel, hwrite, hreadyin, hreadyout, hresp;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [31:0] paddr, pwdata, prdata;

  int   tests = 0;
  int   fails = 0;
  vec_t vecs[13];
  vec_t ahb_q[$];
  vec_t apb_q[$];

  ahbl_to_apb3_bridge #(.APB_AWIDTH(32), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .HCLK(hclk), .HRESETN(hresetn), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADYIN(hreadyin), .HREADYOUT(hreadyout), .HRDATA(hrdata), .HRESP(hresp),
    .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr),
    .PWDATA(pwdata), .PREADY(pready), .PRDATA(prdata), .PSLVERR(pslverr)
  );

  // Single slave on the bus: bus HREADY is this slave's HREADYOUT.
  assign hreadyin = hreadyout;

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(input logic nonseq, input logic write,
                              input logic [31:0] addr, input logic [31:0] data,
                              input int waits, input logic slverr, input int exp_ws,
                              input logic exp_resp, input logic [31:0] exp_hrdata,
                              input int exp_acc);
    vec_t v;
    v.nonseq = nonseq;  v.write = write;       v.addr = addr;
    v.data = data;      v.waits = waits;       v.slverr = slverr;
    v.exp_ws = exp_ws;  v.exp_resp = exp_resp; v.exp_hrdata = exp_hrdata;
    v.exp_acc = exp_acc;
    return v;
  endfunction

  // Drive an address phase and record what it should produce.
  task automatic set_addr(input vec_t v);
    hsel   = 1'b1;
    htrans = v.nonseq ? 2'b10 : 2'b00;
    haddr  = v.addr;
    hwrite = v.write;
    ahb_q.push_back(v);
    if (v.nonseq) apb_q.push_back(v);
  endtask

  task automatic set_idle();
    hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0;
  endtask

  // Issue vecs[first .. first+n-1] back to back; each next address is on the
  // bus for the whole data phase of the previous transfer. Called just after
  // a rising edge with the bridge idle.
  task automatic run_group(input int first, input int n);
    vec_t want;
    int   ws;
    logic prev_resp;
    set_addr(vecs[first]);
    @(posedge hclk); #1;
    for (int k = 0; k < n; k++) begin
      hwdata = vecs[first + k].data;
      if (k + 1 < n) set_addr(vecs[first + k + 1]);
      else           set_idle();
      ws = 0;
      prev_resp = 1'b0;
      @(negedge hclk);
      while (hreadyout !== 1'b1 && ws < MAX_WAIT) begin
        ws++;
        prev_resp = hresp;
        @(negedge hclk);
      end
      want = ahb_q.pop_front();
      check($sformatf("v%0d_wait_states", first + k), 32'(ws), 32'(want.exp_ws));
      check($sformatf("v%0d_hresp", first + k), 32'(hresp), 32'(want.exp_resp));
      check($sformatf("v%0d_hrdata", first + k), hrdata, want.exp_hrdata);
      if (ws > 0)
        check($sformatf("v%0d_hresp_last_wait", first + k), 32'(prev_resp),
              32'(want.exp_resp));
      @(posedge hclk); #1;
    end
  endtask

  // APB slave: inputs change on the falling edge, so the bridge samples
  // them on the following rising edge.
  initial begin : apb_slave
    vec_t cur;
    bit   active;
    int   acc;
    active = 1'b0; acc = 0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    cur = mk(1'b0, 1'b0, '0, '0, 0, 1'b0, 0, 1'b0, '0, 0);
    forever begin
      @(negedge hclk);
      if (!hresetn) begin
        active = 1'b0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
      end else if (psel && !penable) begin
        check("apb_setup_expected", 32'(apb_q.size() != 0), 32'd1);
        active = 1'b0;
        if (apb_q.size() != 0) begin
          cur = apb_q.pop_front();
          active = 1'b1;
          acc = 0;
          check($sformatf("apb_setup_paddr_%08h", cur.addr), paddr, cur.addr);
          check($sformatf("apb_setup_pwrite_%08h", cur.addr), 32'(pwrite), 32'(cur.write));
          if (cur.write)
            check($sformatf("apb_setup_pwdata_%08h", cur.addr), pwdata, cur.data);
        end
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
      end else if (psel && penable && active) begin
        acc++;
        check($sformatf("apb_access_paddr_%08h", cur.addr), paddr, cur.addr);
        if (cur.write)
          check($sformatf("apb_access_pwdata_%08h", cur.addr), pwdata, cur.data);
        // PSLVERR is driven even while PREADY is low; it must be ignored then.
        pready  = (acc > cur.waits);
        prdata  = pready ? cur.data : ~cur.data;
        pslverr = cur.slverr;
      end else begin
        if (active) begin
          check($sformatf("apb_access_cycles_%08h", cur.addr), 32'(acc), 32'(cur.exp_acc));
          active = 1'b0;
        end
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t rst_v;
    //            nonseq wr    addr          data          waits  err   ws resp hrdata        acc
    vecs[0]  = mk(1'b1, 1'b0, 32'h4000_0010, 32'hCAFE_F00D, 0,     1'b0, 2, 1'b0, 32'hCAFE_F00D, 1);
    vecs[1]  = mk(1'b1, 1'b1, 32'h4000_0004, 32'h1234_5678, 3,     1'b0, 6, 1'b0, 32'hCAFE_F00D, 4);
    vecs[2]  = mk(1'b1, 1'b0, 32'h4000_0008, 32'h1111_2222, 0,     1'b1, 3, 1'b1, 32'hCAFE_F00D, 1);
    vecs[3]  = mk(1'b0, 1'b0, 32'h4000_0008, 32'h0000_0000, 0,     1'b0, 0, 1'b0, 32'hCAFE_F00D, 0);
    vecs[4]  = mk(1'b1, 1'b0, 32'h4000_000C, 32'h3333_4444, STUCK, 1'b0, 6, 1'b1, 32'hCAFE_F00D, 4);
    vecs[5]  = mk(1'b1, 1'b0, 32'h4000_0014, 32'h5A5A_0F0F, 3,     1'b0, 5, 1'b0, 32'h5A5A_0F0F, 4);
    vecs[6]  = mk(1'b1, 1'b1, 32'h4000_0100, 32'hA5A5_0001, 0,     1'b0, 3, 1'b0, 32'h5A5A_0F0F, 1);
    vecs[7]  = mk(1'b1, 1'b0, 32'h4000_0104, 32'h0BAD_CAFE, 1,     1'b0, 3, 1'b0, 32'h0BAD_CAFE, 2);
    vecs[8]  = mk(1'b0, 1'b0, 32'h4000_0104, 32'h0000_0000, 0,     1'b0, 0, 1'b0, 32'h0BAD_CAFE, 0);
    vecs[9]  = mk(1'b1, 1'b1, 32'h4000_0108, 32'hFFFF_0000, 2,     1'b1, 6, 1'b1, 32'h0BAD_CAFE, 3);
    vecs[10] = mk(1'b1, 1'b0, 32'h4000_010C, 32'h7777_8888, 0,     1'b0, 2, 1'b0, 32'h7777_8888, 1);
    vecs[11] = mk(1'b1, 1'b1, 32'h4000_0200, 32'h0F0F_0F0F, STUCK, 1'b0, 7, 1'b1, 32'h7777_8888, 4);
    vecs[12] = mk(1'b1, 1'b0, 32'h4000_0300, 32'h600D_F00D, 0,     1'b0, 2, 1'b0, 32'h600D_F00D, 1);

    hresetn = 1'b0;
    set_idle();
    hsize  = 3'b010;
    hburst = 3'b000;
    hwdata = '0;
    repeat (2) @(negedge hclk);
    check("reset_hreadyout", 32'(hreadyout), 32'd1);
    check("reset_hresp",     32'(hresp),     32'd0);
    check("reset_hrdata",    hrdata,         32'd0);
    check("reset_psel",      32'(psel),      32'd0);
    check("reset_penable",   32'(penable),   32'd0);
    check("reset_pwrite",    32'(pwrite),    32'd0);
    check("reset_paddr",     paddr,          32'd0);
    check("reset_pwdata",    pwdata,         32'd0);
    hresetn = 1'b1;
    @(posedge hclk); #1;

    run_group(0, 1);   // plain read, zero-wait APB
    run_group(1, 1);   // write with three PREADY-low ACCESS cycles
    run_group(2, 2);   // PSLVERR read, then IDLE transfer gets OKAY
    run_group(4, 1);   // PREADY stuck low: timeout after 4 ACCESS cycles
    run_group(5, 1);   // PREADY on the 4th ACCESS cycle wins over timeout
    run_group(6, 5);   // back-to-back write/read/idle/error-write/read
    run_group(11, 1);  // write timeout

    // Reset pulsed during ACCESS must clear the bus outputs without a clock edge.
    rst_v = mk(1'b1, 1'b0, 32'h4000_0020, 32'h0, STUCK, 1'b0, 0, 1'b0, 32'h0, 0);
    apb_q.push_back(rst_v);
    hsel = 1'b1; htrans = 2'b10; haddr = rst_v.addr; hwrite = 1'b0;
    @(posedge hclk); #1;
    set_idle();
    @(posedge hclk); #1;
    @(posedge hclk);
    @(negedge hclk);
    check("rst_mid_penable_before", 32'(penable), 32'd1);
    #2 hresetn = 1'b0;
    #1;
    check("rst_mid_psel",      32'(psel),      32'd0);
    check("rst_mid_penable",   32'(penable),   32'd0);
    check("rst_mid_hreadyout", 32'(hreadyout), 32'd1);
    check("rst_mid_hresp",     32'(hresp),     32'd0);
    check("rst_mid_paddr",     paddr,          32'd0);
    check("rst_mid_pwdata",    pwdata,         32'd0);
    check("rst_mid_hrdata",    hrdata,         32'd0);
    @(negedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk); #1;
    run_group(12, 1);  // fresh read after reset release

    repeat (3) @(posedge hclk);
    @(negedge hclk);
    check("apb_queue_drained", 32'(apb_q.size()), 32'd0);
    check("ahb_queue_drained", 32'(ahb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ahbl_to_apb3_bridge.md
# ahbl_to_apb3_bridge

AHB-Lite slave to APB3 master bridge, directly downstream of the AXI-to-AHB-Lite bridge on the same HCLK domain. It converts each AHB-Lite NONSEQ/SEQ transfer into one APB3 setup/access transaction. It inserts AHB wait states until PREADY and maps PSLVERR, or an optional access timeout, to a two-cycle AHB ERROR response.

## Interface
Parameters:
- APB_AWIDTH, 32: PADDR width; PADDR = HADDR[APB_AWIDTH-1:0] (1..32).
- TIMEOUT_CYCLES, 0: maximum ACCESS cycles before abort; 0 disables timeout (1..255 otherwise).

Ports:
- HCLK  in  1  single clock for AHB and APB sides.
- HRESETN  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  32  address-phase address.
- HTRANS  in  2  transfer type; bit 1 set = NONSEQ/SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  captured, unused (APB3 is word-only).
- HBURST  in  3  ignored; each beat is an independent transfer.
- HWDATA  in  32  write data, valid in the data phase.
- HREADYIN  in  1  bus HREADY; qualifies the address phase.
- HREADYOUT  out  1  registered; 0 = wait state.
- HRDATA  out  32  registered read data.
- HRESP  out  1  registered; 1 = ERROR.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  APB_AWIDTH  APB address.
- PWDATA  out  32  APB write data.
- PREADY  in  1  APB ready.
- PRDATA  in  32  APB read data.
- PSLVERR  in  1  APB error.

## Operation
- Valid address phase: HSEL & HREADYIN & HTRANS[1] sampled in IDLE or ERR2. Captures HADDR and HWRITE; HREADYOUT goes to 0 on the same edge.
- States:
  - IDLE: HREADYOUT=1, HRESP=0. On a valid address phase, go to WDATA if write, else SETUP. HSEL with IDLE/BUSY HTRANS gives a zero-wait OKAY and no APB activity.
  - WDATA: latch HWDATA into PWDATA; go to SETUP.
  - SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE stable; go to ACCESS.
  - ACCESS: PSEL=1, PENABLE=1. Exit priority:
    - PREADY & PSLVERR: go to ERR1.
    - PREADY & !PSLVERR: go to IDLE. HREADYOUT=1; on reads, HRDATA←PRDATA.
    - Timeout (counter reaches TIMEOUT_CYCLES without PREADY): drop PSEL/PENABLE, go to ERR1.
  - ERR1: HREADYOUT=0, HRESP=1; go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Next state is IDLE, or WDATA/SETUP if a valid address phase is sampled.
- PSEL and PENABLE are both 0 on the edge leaving ACCESS.
- PADDR, PWRITE and PWDATA hold their last values while idle.
- Timeout counter: reset to 0 on SETUP→ACCESS, increments each ACCESS cycle with PREADY=0. Width is ceil(log2(TIMEOUT_CYCLES+1)), minimum 1.
- PREADY in the same cycle the timeout is reached takes priority over the timeout.
- HRDATA holds its value after writes and errors.

## Timing
- All outputs are registered.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, state IDLE.
- HRESETN assertion mid-transfer forces reset values immediately (asynchronously), including dropping PSEL.
- Read, PREADY tied high: address phase at cycle 0; SETUP at 1; ACCESS at 2; HREADYOUT=1 with data at 3. That is 2 wait states.
- Write: one extra cycle (WDATA), giving 3 wait states minimum.
- Each ACCESS cycle with PREADY=0 adds one wait state.
- Back-to-back: a new address phase is accepted in the same cycle HREADYOUT=1 completes the previous transfer. There is no idle gap on AHB; APB SETUP follows one cycle later.

## Test plan
- Read 0x4000_0010, PREADY=1, PRDATA=0xCAFE_F00D -> PSEL high cycles 1–2, PENABLE cycle 2, HRDATA=0xCAFE_F00D with HREADYOUT=1 at cycle 3, HRESP=0.
- Write 0x4000_0004 with HWDATA=0x1234_5678, PREADY low for 3 ACCESS cycles -> PWDATA=0x1234_5678 stable through SETUP/ACCESS, PWRITE=1, 6 wait states total.
- Read with PSLVERR=1 at PREADY -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), then IDLE OKAY.
- TIMEOUT_CYCLES=4, PREADY stuck 0 -> PSEL deasserted after 4 ACCESS cycles, two-cycle ERROR response. Repeat with PREADY=1 on the 4th cycle -> OKAY.
- Back-to-back write then read, plus HSEL=1 with HTRANS=IDLE -> both APB transactions in order with no dropped address; IDLE transfer gives zero-wait OKAY and PSEL=0.
- HRESETN pulsed low during ACCESS -> PSEL/PENABLE=0 and HREADYOUT=1 asynchronously; a fresh read after release completes normally.
